sar_adc_ctrl_multi: RTL and testbench

Parametrised digital controller for a successive-approximation ADC: generalises the fixed 4-bit single-channel SAR to WIDTH bits and NUM_CH multiplexed analog channels.
- Drives the analog front-end: sample switch, channel mux select and DAC code.
- Resolves one bit per trial from the external comparator.
- Supports single-shot and continuous round-robin scan modes.
- Sits between the analog macro (on ua pins) and the digital I/O wrapper of the tile.

---
 rtl/sar_adc_pkg.sv | 41 ++++
 rtl/sar_chan_scheduler.sv | 44 ++++
 rtl/sar_adc_ctrl_multi.sv | 156 +++++++++++++++
 tb/tb_sar_adc_ctrl_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC controller:
// FSM state encoding, channel-select width and round-robin channel search.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_TRIAL  = 2'd2,
    ST_DONE   = 2'd3
  } sar_state_e;

  localparam int MAX_CH = 8;

  function automatic int cw(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Lowest set bit of mask at or above ptr, wrapping through channel n-1 back to 0.
  function automatic logic [2:0] next_channel(input logic [7:0] mask,
                                              input logic [2:0] ptr,
                                              input int n);
    logic [2:0] sel;
    logic       found;
    int         idx;
    sel   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = (int'(ptr) + i) % n;
      if ((i < n) && !found && mask[3'(idx)]) begin
        sel   = 3'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sar_chan_scheduler.sv
// Round-robin channel scheduler: owns the scan pointer and offers the channel to
// start a scan on plus the channel that follows the one currently converting.
module sar_chan_scheduler
  import sar_adc_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = cw(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] mask,
  input  logic [CW-1:0]     cur_ch,
  input  logic              advance,
  output logic [CW-1:0]     first_ch,
  output logic [CW-1:0]     follow_ch
);

  logic [CW-1:0] ptr;
  logic [CW-1:0] after_cur;
  logic [7:0]    mask_wide;

  always_comb begin
    mask_wide               = 8'd0;
    mask_wide[NUM_CH-1:0]   = mask;
    if (cur_ch == CW'(NUM_CH - 1)) begin
      after_cur = {CW{1'b0}};
    end else begin
      after_cur = cur_ch + CW'(1);
    end
    first_ch  = CW'(next_channel(mask_wide, 3'(ptr), NUM_CH));
    follow_ch = CW'(next_channel(mask_wide, 3'(after_cur), NUM_CH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= {CW{1'b0}};
    end else if (advance) begin
      ptr <= after_cur;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl_multi.sv
// Successive-approximation ADC controller, WIDTH bits over NUM_CH multiplexed
// channels, with single-shot and continuous round-robin scan modes.
module sar_adc_ctrl_multi
  import sar_adc_pkg::*;
#(
  parameter  int WIDTH         = 4,
  parameter  int NUM_CH        = 4,
  parameter  int SAMPLE_CYCLES = 2,
  parameter  int SETTLE_CYCLES = 1,
  localparam int CW            = cw(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont_mode,
  input  logic [CW-1:0]     ch_sel,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              cmp_in,
  output logic              sample_en,
  output logic [CW-1:0]     ch_mux,
  output logic [WIDTH-1:0]  dac_code,
  output logic              busy,
  output logic [WIDTH-1:0]  data_out,
  output logic [CW-1:0]     data_ch,
  output logic              data_valid
);

  localparam int               SLOTS       = 1 << CW;
  localparam logic [SLOTS-1:0] CH_OK       = SLOTS'((64'd1 << NUM_CH) - 64'd1);
  localparam logic [WIDTH-1:0] TOP_BIT     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [15:0]      SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES);

  sar_state_e       state;
  logic             mode_cont;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] bit_mask;
  logic [15:0]      cnt;

  logic [WIDTH-1:0] res_next;
  logic             accept;
  logic             advance;
  logic [CW-1:0]    first_ch;
  logic [CW-1:0]    follow_ch;
  logic [CW-1:0]    start_ch;

  sar_chan_scheduler #(
    .NUM_CH (NUM_CH)
  ) u_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .mask      (ch_mask),
    .cur_ch    (ch_mux),
    .advance   (advance),
    .first_ch  (first_ch),
    .follow_ch (follow_ch)
  );

  // bit_mask is one-hot on the bit under trial; res_next resolves it from the comparator.
  always_comb begin
    if (cmp_in) begin
      res_next = result | bit_mask;
    end else begin
      res_next = result & ~bit_mask;
    end
    if (cont_mode) begin
      accept   = start && (|ch_mask);
      start_ch = first_ch;
    end else begin
      accept   = start && CH_OK[ch_sel];
      start_ch = ch_sel;
    end
    advance = (state == ST_DONE) && mode_cont && cont_mode && (|ch_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_cont  <= 1'b0;
      result     <= {WIDTH{1'b0}};
      bit_mask   <= {WIDTH{1'b0}};
      cnt        <= 16'd0;
      sample_en  <= 1'b0;
      ch_mux     <= {CW{1'b0}};
      dac_code   <= {WIDTH{1'b0}};
      busy       <= 1'b0;
      data_out   <= {WIDTH{1'b0}};
      data_ch    <= {CW{1'b0}};
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SAMPLE;
            mode_cont <= cont_mode;
            ch_mux    <= start_ch;
            sample_en <= 1'b1;
            busy      <= 1'b1;
            cnt       <= 16'd0;
            dac_code  <= {WIDTH{1'b0}};
          end
        end
        ST_SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            state     <= ST_TRIAL;
            sample_en <= 1'b0;
            cnt       <= 16'd0;
            result    <= {WIDTH{1'b0}};
            bit_mask  <= TOP_BIT;
            dac_code  <= TOP_BIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_TRIAL: begin
          if (cnt == SETTLE_LAST) begin
            cnt      <= 16'd0;
            result   <= res_next;
            bit_mask <= bit_mask >> 1;
            if (bit_mask[0]) begin
              state      <= ST_DONE;
              dac_code   <= {WIDTH{1'b0}};
              data_out   <= res_next;
              data_ch    <= ch_mux;
              data_valid <= 1'b1;
            end else begin
              dac_code <= res_next | (bit_mask >> 1);
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          // Scan continues only while still in scan mode and some channel is enabled.
          if (advance) begin
            state     <= ST_SAMPLE;
            ch_mux    <= follow_ch;
            sample_en <= 1'b1;
            cnt       <= 16'd0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sample_en <= 1'b0;
          dac_code  <= {WIDTH{1'b0}};
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl_multi.sv
// Self-checking bench for sar_adc_ctrl_multi: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a phase-based model.
module tb_sar_adc_ctrl_multi;

  localparam int WIDTH  = 4;
  localparam int NUM_CH = 4;
  localparam int SAMPLE = 2;
  localparam int SETTLE = 1;
  localparam int CW     = 2;
  localparam int TOTAL  = SAMPLE + WIDTH * (SETTLE + 1);

  logic              clk = 1'b0;
  logic              rst_n, start, cont_mode, cmp_in;
  logic [CW-1:0]     ch_sel;
  logic [NUM_CH-1:0] ch_mask;
  logic              sample_en, busy, data_valid;
  logic [CW-1:0]     ch_mux, data_ch;
  logic [WIDTH-1:0]  dac_code, data_out;

  int vin   [NUM_CH];
  int s_vin [NUM_CH];
  logic s_rst, s_start, s_cont;
  logic [CW-1:0] s_sel;
  logic [NUM_CH-1:0] s_mask;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_busy = 0, m_phase = 0, m_ch = 0, m_cont = 0, m_ptr = 0, m_res = 0;
  int m_dout = 0, m_dch = 0, m_dv = 0;

  always #5 clk = ~clk;

  // Each analog input sits half an LSB above its code, so the comparator trips while dac <= vin.
  assign cmp_in = (vin[ch_mux] >= int'(dac_code));

  sar_adc_ctrl_multi #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .SAMPLE_CYCLES(SAMPLE), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont_mode(cont_mode), .ch_sel(ch_sel),
    .ch_mask(ch_mask), .cmp_in(cmp_in), .sample_en(sample_en), .ch_mux(ch_mux),
    .dac_code(dac_code), .busy(busy), .data_out(data_out), .data_ch(data_ch),
    .data_valid(data_valid)
  );

  always @(posedge clk) begin
    s_rst   <= rst_n;
    s_start <= start;
    s_cont  <= cont_mode;
    s_sel   <= ch_sel;
    s_mask  <= ch_mask;
    s_vin   <= vin;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int mask, input int ptr);
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    if (!s_rst) begin
      m_busy = 0; m_phase = 0; m_ch = 0; m_cont = 0; m_ptr = 0;
      m_dout = 0; m_dch = 0; m_dv = 0;
    end else begin
      m_dv = 0;
      if (m_busy == 0) begin
        if (s_start && (s_cont ? (s_mask != 0) : (int'(s_sel) < NUM_CH))) begin
          m_busy = 1; m_cont = int'(s_cont); m_phase = 0;
          m_ch   = s_cont ? pick(int'(s_mask), m_ptr) : int'(s_sel);
          m_res  = s_vin[m_ch];
        end
      end else begin
        m_phase++;
        if (m_phase == TOTAL) begin
          m_dv = 1; m_dout = m_res; m_dch = m_ch;
        end else if (m_phase == TOTAL + 1) begin
          if (m_cont == 0 || !s_cont || s_mask == 0) begin
            m_busy = 0;
          end else begin
            m_ptr = (m_ch + 1) % NUM_CH;
            m_ch = pick(int'(s_mask), m_ptr); m_phase = 0; m_res = s_vin[m_ch];
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    int e_dac, e_se, k;
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
      e_se = (m_busy != 0 && m_phase < SAMPLE) ? 1 : 0;
      e_dac = 0;
      if (m_busy != 0 && m_phase >= SAMPLE && m_phase < TOTAL) begin
        k = WIDTH - 1 - (m_phase - SAMPLE) / (SETTLE + 1);
        e_dac = ((m_res >> (k + 1)) << (k + 1)) | (1 << k);
      end
      check("busy", int'(busy), m_busy);
      check("sample_en", int'(sample_en), e_se);
      check("dac_code", int'(dac_code), e_dac);
      check("ch_mux", int'(ch_mux), m_ch);
      check("data_valid", int'(data_valid), m_dv);
      check("data_out", int'(data_out), m_dout);
      check("data_ch", int'(data_ch), m_dch);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic c, input int s, input int m);
    @(negedge clk);
    start = 1'b1; cont_mode = c; ch_sel = CW'(s); ch_mask = NUM_CH'(m);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; ch_sel = '0; ch_mask = '0;
    for (int i = 0; i < NUM_CH; i++) vin[i] = 0;
    wait_cyc(3);
    check("rst_busy", int'(busy), 0);
    check("rst_dout", int'(data_out), 0);
    check("rst_dac", int'(dac_code), 0);
    rst_n = 1'b1;

    // single-shot ch2, Vin=11: trial codes 8,12,10,11
    vin[2] = 11;
    do_start(1'b0, 2, 0);
    wait_cyc(2); check("seq_8", int'(dac_code), 8);
    wait_cyc(2); check("seq_12", int'(dac_code), 12);
    wait_cyc(2); check("seq_10", int'(dac_code), 10);
    wait_cyc(2); check("seq_11", int'(dac_code), 11);
    wait_cyc(2);
    check("ss_valid", int'(data_valid), 1);
    check("ss_dout", int'(data_out), 11);
    check("ss_dch", int'(data_ch), 2);
    wait_cyc(1);
    check("ss_busy_low", int'(busy), 0);
    check("ss_valid_low", int'(data_valid), 0);

    // extremes
    vin[0] = 0;  do_start(1'b0, 0, 0); wait_cyc(10); check("vin0", int'(data_out), 0);
    wait_cyc(1);
    vin[0] = 15; do_start(1'b0, 0, 0); wait_cyc(10); check("vin15", int'(data_out), 15);
    wait_cyc(1);

    // scan mask 1010
    vin[0] = 3; vin[1] = 9; vin[2] = 5; vin[3] = 14;
    do_start(1'b1, 0, 4'b1010);
    wait_cyc(10);
    check("scan1_valid", int'(data_valid), 1);
    check("scan1_ch", int'(data_ch), 1); check("scan1_d", int'(data_out), 9);
    wait_cyc(11);
    check("scan2_valid", int'(data_valid), 1);
    check("scan2_ch", int'(data_ch), 3); check("scan2_d", int'(data_out), 14);
    wait_cyc(11);
    check("scan3_ch", int'(data_ch), 1); check("scan3_d", int'(data_out), 9);
    wait_cyc(3);
    cont_mode = 1'b0;
    wait_cyc(8);
    check("stop_valid", int'(data_valid), 1);
    check("stop_ch", int'(data_ch), 3); check("stop_d", int'(data_out), 14);
    wait_cyc(1); check("stop_busy", int'(busy), 0);
    wait_cyc(12); check("stop_nosample", int'(sample_en), 0);

    // reset mid-trial
    vin[1] = 6;
    do_start(1'b0, 1, 0);
    wait_cyc(4);
    rst_n = 1'b0;
    wait_cyc(1);
    check("mrst_busy", int'(busy), 0); check("mrst_dac", int'(dac_code), 0);
    check("mrst_mux", int'(ch_mux), 0); check("mrst_dout", int'(data_out), 0);
    rst_n = 1'b1;
    wait_cyc(1);
    do_start(1'b0, 1, 0); wait_cyc(10);
    check("post_rst_d", int'(data_out), 6); check("post_rst_ch", int'(data_ch), 1);
    wait_cyc(1);

    // ignored starts
    do_start(1'b1, 0, 0);
    check("mask0_ign", int'(busy), 0);
    vin[3] = 7;
    do_start(1'b0, 3, 0);
    wait_cyc(2);
    start = 1'b1; cont_mode = 1'b1; ch_sel = 2'd0; ch_mask = 4'b1111;
    wait_cyc(1);
    start = 1'b0; cont_mode = 1'b0;
    wait_cyc(7);
    check("busy_ign_d", int'(data_out), 7); check("busy_ign_ch", int'(data_ch), 3);
    wait_cyc(1); check("busy_ign_idle", int'(busy), 0);

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      start = 1'b0;
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if (busy == 1'b0 && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NUM_CH; i++) vin[i] = $urandom_range(0, 15);
      end else if ($urandom_range(0, 4) == 0) begin
        start     = 1'b1;
        cont_mode = ($urandom_range(0, 2) == 0);
        ch_sel    = CW'($urandom_range(0, NUM_CH - 1));
        ch_mask   = NUM_CH'($urandom_range(0, 15));
      end
      if (cont_mode && $urandom_range(0, 39) == 0) cont_mode = 1'b0;
      if ($urandom_range(0, 29) == 0) ch_mask = NUM_CH'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0; rst_n = 1'b1;
    wait_cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
